ram16k_optim: RTL and testbench

RAM16K_OPTIM -- requirements
Module: ram16k_optim

---
 rtl/ram16k_optim_pkg.sv | 18 +
 rtl/ram16k_optim_ram4k.sv | 30 +++
 rtl/ram16k_optim.sv | 57 +++++
 tb/tb_ram16k_optim.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ram16k_optim_pkg.sv
// Shared constants and types for the 16K-word RAM and its 4K-word banks.
package ram16k_optim_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned ADDR_W      = 14;
  localparam int unsigned DEPTH       = 1 << ADDR_W;

  // Upper address bits pick one of four equal banks.
  localparam int unsigned BANK_SEL_W  = 2;
  localparam int unsigned NUM_BANKS   = 1 << BANK_SEL_W;
  localparam int unsigned BANK_ADDR_W = ADDR_W - BANK_SEL_W;
  localparam int unsigned BANK_DEPTH  = 1 << BANK_ADDR_W;

  typedef logic [DATA_W-1:0]      data_t;
  typedef logic [ADDR_W-1:0]      addr_t;
  typedef logic [BANK_ADDR_W-1:0] bank_addr_t;

endpackage

// File: rtl/ram16k_optim_ram4k.sv
// One 4K-word bank: a single inferred array, synchronous write, combinational read.
module ram16k_optim_ram4k
  import ram16k_optim_pkg::*;
#(
  parameter int unsigned DATA_W = ram16k_optim_pkg::DATA_W,
  parameter int unsigned ADDR_W = ram16k_optim_pkg::BANK_ADDR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Contents are zero at configuration and are never touched by reset.
  logic [DATA_W-1:0] mem_q [2**ADDR_W] = '{default: '0};

  // Write port: store on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read port: asynchronous, so a new address shows its word in the same cycle.
  always_comb begin
    rdata_o = mem_q[addr_i];
  end

endmodule

// File: rtl/ram16k_optim.sv
// 16K x 16 RAM (Hack RAM16K semantics) built from four 4K banks.
// Top level holds only bank decode, the output mux and reset gating.
module ram16k_optim
  import ram16k_optim_pkg::*;
#(
  parameter int unsigned DATA_W = ram16k_optim_pkg::DATA_W,
  parameter int unsigned ADDR_W = ram16k_optim_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);

  localparam int unsigned BankAw = ADDR_W - BANK_SEL_W;

  logic [BANK_SEL_W-1:0] bank_sel;
  logic [BankAw-1:0]     bank_addr;
  logic [NUM_BANKS-1:0]  bank_we;
  logic [DATA_W-1:0]     bank_rdata [NUM_BANKS];

  assign bank_sel  = address[ADDR_W-1 -: BANK_SEL_W];
  assign bank_addr = address[BankAw-1:0];

  // Route load to exactly one bank; reset low blocks every write, including
  // one coincident with a clock edge, since the enable is gated combinationally.
  always_comb begin
    bank_we = '0;
    if (RST_N && load) begin
      bank_we[bank_sel] = 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ram16k_optim_ram4k #(
      .DATA_W (DATA_W),
      .ADDR_W (BankAw)
    ) u_bank (
      .clk_i   (CLK),
      .we_i    (bank_we[b]),
      .addr_i  (bank_addr),
      .wdata_i (in),
      .rdata_o (bank_rdata[b])
    );
  end

  // 4:1 read mux, forced to zero while reset is held (asynchronously).
  always_comb begin
    out = '0;
    if (RST_N) begin
      out = bank_rdata[bank_sel];
    end
  end

endmodule

// File: tb/tb_ram16k_optim.sv
// Self-checking bench for ram16k_optim: directed scenarios plus random
// writes, checked against a flat word-array model of the whole RAM.
module tb_ram16k_optim;

  localparam int unsigned Depth = 16384;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] din;
  logic        load;
  logic [13:0] address;
  logic [15:0] dout;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Reference: one entry per word, zero at power-up.
  logic [15:0] model_mem [Depth];
  logic [13:0] wr_addrs [$];

  always #5 CLK = ~CLK;

  ram16k_optim dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .in      (din),
    .load    (load),
    .address (address),
    .out     (dout)
  );

  task automatic check(input string tag, input logic [15:0] exp);
    vectors++;
    assert (dout === exp) else begin
      errors++;
      $error("FAIL %s: addr=%h out=%h expected=%h", tag, address, dout, exp);
    end
  endtask

  task automatic read_chk(input string tag, input logic [13:0] a);
    @(negedge CLK);
    load    = 1'b0;
    address = a;
    #1;
    check(tag, model_mem[a]);
  endtask

  task automatic write(input logic [13:0] a, input logic [15:0] d);
    @(negedge CLK);
    address = a;
    din     = d;
    load    = 1'b1;
    @(posedge CLK);
    model_mem[a] = d;
    #1;
    load = 1'b0;
  endtask

  initial begin
    logic [13:0] a;
    logic [15:0] d;

    for (int i = 0; i < int'(Depth); i++) model_mem[i] = 16'h0000;

    // Reset held: output forced low regardless of address.
    RST_N   = 1'b0;
    load    = 1'b0;
    din     = 16'h0000;
    address = 14'h0000;
    #1;
    check("reset_out_a0", 16'h0000);
    address = 14'h3FFF;
    #1;
    check("reset_out_a3fff", 16'h0000);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("powerup_zero", model_mem[14'h3FFF]);

    // Boundary addresses.
    write(14'h0000, 16'hBEEF);
    write(14'h3FFF, 16'h1234);
    read_chk("bound_lo", 14'h0000);
    read_chk("bound_hi", 14'h3FFF);

    // Read-during-write: old value before the edge, new value after.
    @(negedge CLK);
    address = 14'h0000;
    din     = 16'hCAFE;
    load    = 1'b1;
    #1;
    check("rdw_before", model_mem[0]);
    @(posedge CLK);
    model_mem[0] = 16'hCAFE;
    #1;
    check("rdw_after", model_mem[0]);
    load = 1'b0;

    // Edge with load low leaves contents alone.
    write(14'h1000, 16'hAAAA);
    @(negedge CLK);
    address = 14'h1000;
    din     = 16'h5555;
    load    = 1'b0;
    @(posedge CLK);
    #1;
    check("no_load", 16'hAAAA);

    // Repeated writes to one address, then the aliases in the other banks.
    write(14'h2ABC, 16'h0001);
    write(14'h2ABC, 16'hFFFF);
    read_chk("alias_2abc", 14'h2ABC);
    read_chk("alias_0abc", 14'h0ABC);
    read_chk("alias_1abc", 14'h1ABC);
    read_chk("alias_3abc", 14'h3ABC);

    // Reset asserted mid-cycle with a pending write: out drops at once, the
    // edge under reset must not write, contents survive.
    write(14'h0042, 16'h0B0B);
    @(negedge CLK);
    address = 14'h0042;
    din     = 16'h7777;
    load    = 1'b1;
    RST_N   = 1'b0;
    #1;
    check("rst_async_out", 16'h0000);
    @(posedge CLK);
    #1;
    check("rst_edge_out", 16'h0000);
    @(negedge CLK);
    load  = 1'b0;
    RST_N = 1'b1;
    #1;
    check("rst_inhibit", 16'h0B0B);
    read_chk("rst_survive_0", 14'h0000);
    read_chk("rst_survive_2abc", 14'h2ABC);

    // First write after release goes through.
    write(14'h0042, 16'h4242);
    read_chk("post_rst_write", 14'h0042);

    // Random writes, then read every written address back.
    for (int i = 0; i < 100; i++) begin
      a = 14'($urandom_range(0, Depth - 1));
      d = 16'($urandom);
      write(a, d);
      wr_addrs.push_back(a);
    end
    foreach (wr_addrs[i]) read_chk("rand_readback", wr_addrs[i]);

    // Random reads anywhere, mostly untouched words.
    for (int i = 0; i < 20; i++) begin
      a = 14'($urandom_range(0, Depth - 1));
      read_chk("rand_read", a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
